// File: rtl/bch_pkg.sv
// rtl/bch_pkg.sv - shared constants, GF(2^4) helper and FSM state type for the BCH syndrome block
package bch_pkg;

  localparam int GF_W = 4;
  localparam int CW_N = 15;

  // x^4 + x + 1, bit 0 is the alpha^0 coefficient
  localparam logic [GF_W:0] PRIM_POLY = 5'b10011;

  // Exponents of alpha used by the three syndrome accumulators
  localparam int ALPHA_EXP1 = 1;
  localparam int ALPHA_EXP2 = 2;
  localparam int ALPHA_EXP3 = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } bch_state_e;

  // Multiply a field element by alpha: shift, then reduce by the primitive polynomial
  function automatic logic [GF_W-1:0] gf_xtime(input logic [GF_W-1:0] a);
    logic [GF_W-1:0] v;
    v = {a[GF_W-2:0], 1'b0};
    if (a[GF_W-1]) v = v ^ PRIM_POLY[GF_W-1:0];
    return v;
  endfunction

endpackage

// File: rtl/gf_mul_const.sv
// rtl/gf_mul_const.sv - combinational GF(2^4) multiply by a fixed power of alpha
// Ports:
//   i_a : field element in
//   o_p : i_a * alpha^POW
module gf_mul_const
  import bch_pkg::*;
#(
  parameter int POW = 1
) (
  input  logic [GF_W-1:0] i_a,
  output logic [GF_W-1:0] o_p
);

  // POW is a constant, so the loop unrolls into a fixed XOR network
  always_comb begin
    o_p = i_a;
    for (int k = 0; k < POW; k++) begin
      o_p = gf_xtime(o_p);
    end
  end

endmodule

// File: rtl/bch_syndrome_calc.sv
// rtl/bch_syndrome_calc.sv - serial BCH(15) syndrome calculator, S1..S3 by Horner accumulation
// Ports:
//   clk, rst           : clock, synchronous active-low reset
//   in_valid/in_sof    : beat qualifier and first-bit (r14) marker
//   in_bit / in_ready  : received bit MSB first, accept handshake
//   S1, S2, S3         : r(alpha), r(alpha^2), r(alpha^3), held until next synd_valid
//   synd_valid         : one-cycle pulse when S1..S3 were loaded
//   sof_err            : one-cycle pulse when a partial codeword was aborted by in_sof
//   synd_zero          : only with BCH_SYND_ZERO_FLAG_EN, high when S1=S2=S3=0
module bch_syndrome_calc
  import bch_pkg::*;
#(
  parameter int N = 15,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_sof,
  input  logic         in_bit,
  output logic         in_ready,
  output logic [M-1:0] S1,
  output logic [M-1:0] S2,
  output logic [M-1:0] S3,
  output logic         synd_valid,
  output logic         sof_err
`ifdef BCH_SYND_ZERO_FLAG_EN
  ,
  output logic         synd_zero
`endif
);

  bch_state_e r_state;
  logic [3:0]   r_count;
  logic [M-1:0] r_acc1, r_acc2, r_acc3;

  logic [M-1:0] w_mul1, w_mul2, w_mul3;
  logic [M-1:0] w_nxt1, w_nxt2, w_nxt3;
  logic [M-1:0] w_bit_ext;
  logic         w_accept;
  logic         w_last;

  gf_mul_const #(.POW(ALPHA_EXP1)) u_mul1 (.i_a(r_acc1), .o_p(w_mul1));
  gf_mul_const #(.POW(ALPHA_EXP2)) u_mul2 (.i_a(r_acc2), .o_p(w_mul2));
  gf_mul_const #(.POW(ALPHA_EXP3)) u_mul3 (.i_a(r_acc3), .o_p(w_mul3));

  assign in_ready  = (r_state != ST_DONE);
  assign w_accept  = in_valid & in_ready;
  assign w_bit_ext = {{(M-1){1'b0}}, in_bit};

  // Horner step: acc_j * alpha^j + r_i
  assign w_nxt1 = w_mul1 ^ w_bit_ext;
  assign w_nxt2 = w_mul2 ^ w_bit_ext;
  assign w_nxt3 = w_mul3 ^ w_bit_ext;

  // Current beat is the N-th bit of the codeword
  assign w_last = (r_count == 4'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_acc1     <= '0;
      r_acc2     <= '0;
      r_acc3     <= '0;
      S1         <= '0;
      S2         <= '0;
      S3         <= '0;
      synd_valid <= 1'b0;
      sof_err    <= 1'b0;
`ifdef BCH_SYND_ZERO_FLAG_EN
      synd_zero  <= 1'b0;
`endif
    end else begin
      synd_valid <= 1'b0;
      sof_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Beats without in_sof are dropped here
          if (w_accept && in_sof) begin
            r_acc1  <= w_bit_ext;
            r_acc2  <= w_bit_ext;
            r_acc3  <= w_bit_ext;
            r_count <= 4'd1;
            r_state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            if (in_sof) begin
              // Restart wins even over the N-th bit; partial word never reaches S1..S3
              r_acc1  <= w_bit_ext;
              r_acc2  <= w_bit_ext;
              r_acc3  <= w_bit_ext;
              r_count <= 4'd1;
              sof_err <= 1'b1;
            end else begin
              r_acc1 <= w_nxt1;
              r_acc2 <= w_nxt2;
              r_acc3 <= w_nxt3;
              if (w_last) begin
                r_count    <= 4'(N);
                S1         <= w_nxt1;
                S2         <= w_nxt2;
                S3         <= w_nxt3;
                synd_valid <= 1'b1;
`ifdef BCH_SYND_ZERO_FLAG_EN
                synd_zero  <= ((w_nxt1 | w_nxt2 | w_nxt3) == '0);
`endif
                r_state    <= ST_DONE;
              end else begin
                r_count <= r_count + 4'd1;
              end
            end
          end
        end
        ST_DONE: begin
          r_count <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_syndrome_calc.sv
// tb/tb_bch_syndrome_calc.sv - self-checking bench for bch_syndrome_calc
module tb_bch_syndrome_calc;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_ready;
  logic [3:0] S1, S2, S3;
  logic       synd_valid;
  logic       sof_err;
`ifdef BCH_SYND_ZERO_FLAG_EN
  logic       synd_zero;
`endif

  always #5 clk = ~clk;

  bch_syndrome_calc #(.N(15), .M(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .S1        (S1),
    .S2        (S2),
    .S3        (S3),
    .synd_valid(synd_valid),
    .sof_err   (sof_err)
`ifdef BCH_SYND_ZERO_FLAG_EN
    ,
    .synd_zero (synd_zero)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] alog [15];

  function automatic logic [3:0] xt(input logic [3:0] a);
    return a[3] ? ({a[2:0], 1'b0} ^ 4'h3) : {a[2:0], 1'b0};
  endfunction

  // Direct evaluation r(alpha^j) = sum of alpha^(j*i) over set bits r_i
  function automatic logic [3:0] syn(input logic [14:0] w, input int j);
    logic [3:0] s;
    s = 4'h0;
    for (int i = 0; i < 15; i++) if (w[i]) s = s ^ alog[(j * i) % 15];
    return s;
  endfunction

  bit         mq[$];
  bit         m_bubble = 1'b0;
  bit         m_started = 1'b0;
  logic [3:0] e_s1 = 0, e_s2 = 0, e_s3 = 0;
  logic       e_sv = 0, e_se = 0, e_ready = 1, e_zero = 0;

  initial begin
    alog[0] = 4'h1;
    for (int k = 1; k < 15; k++) alog[k] = xt(alog[k-1]);
  end

  initial forever begin
    @(posedge clk);
    e_sv = 1'b0;
    e_se = 1'b0;
    if (!rst) begin
      m_started = 1'b1;
      mq.delete();
      m_bubble = 1'b0;
      e_s1 = 0; e_s2 = 0; e_s3 = 0; e_zero = 0;
    end else if (m_bubble) begin
      m_bubble = 1'b0;
    end else if (in_valid) begin
      if (in_sof) begin
        if (mq.size() > 0) e_se = 1'b1;
        mq.delete();
        mq.push_back(in_bit);
      end else if (mq.size() > 0) begin
        mq.push_back(in_bit);
        if (mq.size() == 15) begin
          logic [14:0] w;
          for (int k = 0; k < 15; k++) w[14-k] = mq[k];
          e_s1 = syn(w, 1);
          e_s2 = syn(w, 2);
          e_s3 = syn(w, 3);
          e_zero = (e_s1 == 0) && (e_s2 == 0) && (e_s3 == 0);
          e_sv = 1'b1;
          m_bubble = 1'b1;
          mq.delete();
        end
      end
    end
    e_ready = !m_bubble;
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (m_started) begin
      check("in_ready", in_ready, e_ready);
      check("synd_valid", synd_valid, e_sv);
      check("sof_err", sof_err, e_se);
      check("S1", S1, e_s1);
      check("S2", S2, e_s2);
      check("S3", S3, e_s3);
`ifdef BCH_SYND_ZERO_FLAG_EN
      check("synd_zero", synd_zero, e_zero);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic beat(input logic v, input logic s, input logic b);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) check("ready_timeout", in_ready, 1);
    in_valid = v; in_sof = s; in_bit = b;
    @(posedge clk); #1;
    in_valid = 0; in_sof = 0; in_bit = 0;
  endtask

  task automatic send_word(input string tag, input logic [14:0] w, input int stall_at,
                           input logic exp_se, input logic [3:0] x1, input logic [3:0] x2,
                           input logic [3:0] x3);
    for (int i = 14; i >= 0; i--) begin
      beat(1'b1, i == 14, w[i]);
      if (i == 14) check({tag, "_sof_err"}, sof_err, exp_se);
      if (i == stall_at) repeat (3) begin @(posedge clk); #1; end
    end
    // one cycle after acceptance of r0
    check({tag, "_latency"}, synd_valid, 1);
    check({tag, "_S1"}, S1, x1);
    check({tag, "_S2"}, S2, x2);
    check({tag, "_S3"}, S3, x3);
    check({tag, "_model_S1"}, e_s1, x1);
    check({tag, "_model_S3"}, e_s3, x3);
`ifdef BCH_SYND_ZERO_FLAG_EN
    check({tag, "_zero"}, synd_zero, (x1 == 0) && (x2 == 0) && (x3 == 0));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_synd_valid", synd_valid, 0);
    check("rst_sof_err", sof_err, 0);
    check("rst_S1", S1, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", in_ready, 1);

    // stray beats in IDLE without in_sof are dropped
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b1);
    check("idle_drop", synd_valid, 0);

    send_word("all_zero", 15'h0000, -1, 1'b0, 4'h0, 4'h0, 4'h0);
    send_word("r0_only",  15'h0001, -1, 1'b0, 4'h1, 4'h1, 4'h1);
    send_word("r14_only", 15'h4000, -1, 1'b0, 4'h9, 4'hD, 4'hF);
    send_word("r1_stall", 15'h0002,  7, 1'b0, 4'h2, 4'h4, 4'h8);

    // abort: r14..r9 sent, in_sof arrives where r8 would be
    for (int i = 14; i >= 9; i--) beat(1'b1, i == 14, 1'b1);
    check("abort_S1_held", S1, 4'h2);
    send_word("abort_new", 15'h0001, -1, 1'b1, 4'h1, 4'h1, 4'h1);

    // in_sof together with the 15th bit restarts instead of completing
    for (int i = 14; i >= 1; i--) beat(1'b1, i == 14, 1'b0);
    send_word("sof_on_15th", 15'h4000, -1, 1'b1, 4'h9, 4'hD, 4'hF);

    // reset in the middle of a codeword
    for (int i = 14; i >= 10; i--) beat(1'b1, i == 14, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_S1", S1, 0);
    check("midrst_S3", S3, 0);
    check("midrst_synd_valid", synd_valid, 0);
    check("midrst_sof_err", sof_err, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", in_ready, 1);
    send_word("after_rst", 15'h0002, -1, 1'b0, 4'h2, 4'h4, 4'h8);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bch_syndrome_calc.md
BCH_SYNDROME_CALC -- requirements
Module: bch_syndrome_calc

Interface
REQ-001 The block SHALL have parameter N, default 15, meaning codeword length in bits; only N=15 is supported.
REQ-002 The block SHALL have parameter M, default 4, meaning the GF(2^M) symbol width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning in_bit is valid this cycle.
REQ-006 The block SHALL have port in_sof, input, 1 bit, meaning in_bit is the first codeword bit (r14), qualified by in_valid.
REQ-007 The block SHALL have port in_bit, input, 1 bit, the received codeword bit, sent MSB (r14) first.
REQ-008 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts in_bit this cycle.
REQ-009 The block SHALL have ports S1, S2 and S3, each output, 4 bits, the syndromes r(alpha), r(alpha^2) and r(alpha^3).
REQ-010 The block SHALL have port synd_valid, output, 1 bit, a one-cycle pulse meaning S1..S3 were updated.
REQ-011 The block SHALL have port sof_err, output, 1 bit, a one-cycle pulse meaning a codeword was aborted by an early in_sof.

Function
REQ-012 GF arithmetic SHALL use the primitive polynomial x^4+x+1, with bit 0 as the alpha^0 coefficient.
REQ-013 The FSM SHALL have states IDLE, ACCUM and DONE; a beat is accepted when in_valid and in_ready are both 1.
REQ-014 In IDLE, in_ready SHALL be 1; a beat without in_sof SHALL be dropped, and a beat with in_sof SHALL go to ACCUM with accumulators set to {0,0,0,in_bit} and bit count 1.
REQ-015 In ACCUM, each accepted beat SHALL update acc_j <= acc_j*alpha^j XOR in_bit for j=1..3 (Horner) and increment the count.
REQ-016 When in_valid is 0 in ACCUM, the accumulators and count SHALL hold.
REQ-017 When the 15th bit is accepted (count reaches N), the next state SHALL be DONE.
REQ-018 On entering DONE, the final accumulators SHALL be loaded into S1..S3, and synd_valid SHALL be 1 for that one DONE cycle.
REQ-019 Latency SHALL be one cycle from acceptance of bit r0 to synd_valid.
REQ-020 In DONE, in_ready SHALL be 0, which gives exactly one bubble per codeword; the next state SHALL be IDLE.
REQ-021 S1..S3 SHALL hold their values until the next synd_valid.
REQ-022 An in_sof beat accepted in ACCUM SHALL discard the partial codeword, restart accumulation with that bit as r14 (count 1), and pulse sof_err next cycle.
REQ-023 An aborted codeword SHALL NOT produce synd_valid, and S1..S3 SHALL be unchanged by it.
REQ-024 in_sof arriving together with the 15th bit SHALL take priority as a restart: there is no DONE, and sof_err pulses.
REQ-025 The bit count SHALL be 4 bits wide and SHALL never exceed N.

Reset
REQ-026 While rst=0 at a clock edge, the state SHALL go to IDLE, and the count, the accumulators, S1..S3, synd_valid and sof_err SHALL all be 0.
REQ-027 Reset asserted mid-codeword SHALL drop the partial codeword with no synd_valid and no sof_err.
REQ-028 in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-029 With macro BCH_SYND_ZERO_FLAG_EN defined, the block SHALL have an extra output port synd_zero, 1 bit, registered with S1..S3 and equal to 1 when S1=S2=S3=0 (no error); it SHALL reset to 0.
REQ-030 Without the macro, the synd_zero port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Shared package bch_pkg SHALL hold the GF width, N, the primitive polynomial constant, the alpha power constants and the FSM state enum.
REQ-032 One sub-module, gf_mul_const, SHALL be used: a combinational multiply by a fixed power of alpha, instantiated three times (alpha^1, alpha^2, alpha^3).

Verification
REQ-033 The bench SHALL cover: an all-zero codeword -> synd_valid one cycle after the 15th bit, with S1=S2=S3=0 (and synd_zero=1 if enabled).
REQ-034 The bench SHALL cover: only the last bit (r0) = 1 -> S1=1, S2=1, S3=1.
REQ-035 The bench SHALL cover: only the first bit (r14) = 1 -> S1=4'h9, S2=4'hD, S3=4'hF.
REQ-036 The bench SHALL cover: only r1 = 1, with in_valid deasserted for 3 cycles mid-word -> S1=4'h2, S2=4'h4, S3=4'h8, and latency unchanged after the stall.
REQ-037 The bench SHALL cover: in_sof at bit 8, then a full r0-only codeword -> sof_err pulses once, then S1=S2=S3=1; the prior S values are held until then.
REQ-038 The bench SHALL cover: rst=0 at bit 10, then a new codeword -> no synd_valid for the aborted word, all outputs 0, and the correct syndromes for the new word.
